// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared constants and FSM state type for the sequential
//               integer-to-single-precision converter.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int INT_W = 32;

    // Exponent of a magnitude whose MSB sits at bit INT_W-1.
    localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + INT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_round.sv
`default_nettype none
// ============================================================================
// Module      : fp_round
// Description : Combinational mantissa rounding. With INT_TO_FP_RNE_EN
//               defined it rounds to nearest-even; otherwise it truncates.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] man_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             guard,
    input  logic             sticky,
    output logic [MAN_W-1:0] man_out,
    output logic [EXP_W-1:0] exp_out
);

`ifdef INT_TO_FP_RNE_EN
    logic           round_up;
    logic [MAN_W:0] sum;

    assign round_up = guard & (sticky | man_in[0]);
    assign sum      = {1'b0, man_in} + {{MAN_W{1'b0}}, round_up};

    // A carry out leaves the low bits at zero already; bump the exponent.
    always_comb begin
        man_out = sum[MAN_W-1:0];
        exp_out = exp_in + {{(EXP_W-1){1'b0}}, sum[MAN_W]};
    end
`else
    logic unused_round;

    // Truncation: guard and sticky have no effect on the result.
    assign unused_round = guard ^ sticky;

    always_comb begin
        man_out = man_in;
        exp_out = exp_in;
    end
`endif

endmodule : fp_round
`default_nettype wire

// File: rtl/int_to_fp_seq.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp_seq
// Description : Sequential signed 32-bit integer to IEEE-754 single
//               converter. Normalises one bit per cycle, then rounds and
//               holds the result until the consumer accepts it.
//               Optional macro: INT_TO_FP_RNE_EN (round to nearest-even;
//               truncation when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_fp_seq
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INT_W-1:0]  in_int,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_fp,
    output logic              busy
);

    state_t             state;
    state_t             next_state;
    logic [INT_W-1:0]   mag;
    logic [EXP_W-1:0]   exp;
    logic               sign;
    logic [MAN_W-1:0]   man_rnd;
    logic [EXP_W-1:0]   exp_rnd;

    fp_round u_round (
        .man_in  (mag[INT_W-2 -: MAN_W]),
        .exp_in  (exp),
        .guard   (mag[INT_W-2-MAN_W]),
        .sticky  (|mag[INT_W-3-MAN_W:0]),
        .man_out (man_rnd),
        .exp_out (exp_rnd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; zero skips normalisation entirely.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (in_valid) next_state = (in_int == '0) ? DONE : NORM;
            NORM:    if (mag[INT_W-1]) next_state = ROUND;
            ROUND:   next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: capture, normalise one bit per cycle, pack the rounded result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sign   <= 1'b0;
            mag    <= '0;
            exp    <= '0;
            out_fp <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= in_int[INT_W-1];
                        // Two's-complement negate; 0x80000000 maps to itself.
                        mag  <= in_int[INT_W-1] ? (~in_int + INT_W'(1)) : in_int;
                        exp  <= EXP_INIT;
                        if (in_int == '0) begin
                            out_fp <= '0;
                        end
                    end
                end
                NORM: begin
                    if (!mag[INT_W-1]) begin
                        mag <= mag << 1;
                        exp <= exp - EXP_W'(1);
                    end
                end
                ROUND: begin
                    out_fp <= {sign, exp_rnd, man_rnd};
                end
                default: begin
                end
            endcase
        end
    end

endmodule : int_to_fp_seq
`default_nettype wire

// File: tb/tb_int_to_fp_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_to_fp_seq
// Description : Directed self-checking bench for int_to_fp_seq. Expected
//               results follow the INT_TO_FP_RNE_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_to_fp_seq;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic        busy;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] in_int;
        logic [31:0] fp;
        int          lat;   // edges after the accept edge until out_valid
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int_to_fp_seq dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_int    (in_int),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Offer one operand and measure edges until out_valid appears.
    task automatic run_op(input logic [31:0] v, output logic [31:0] fp, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_int   = v;
        in_valid = 1'b1;
        @(posedge clk);   // accept edge
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        fp = out_fp;
    endtask

    // Accept the pending result and check the return to IDLE.
    task automatic consume(input logic [31:0] held);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_consume",  {31'd0, in_ready},  32'd1);
        check("out_fp_kept_after_done",  out_fp, held);
    endtask

    initial begin
        logic [31:0] fp;
        logic [31:0] held;
        int          lat;
        int          seen;

        n_checks = 0;
        n_fail   = 0;

`ifdef INT_TO_FP_RNE_EN
        vecs[5] = '{32'h7FFFFFFF, 32'h4F000000, 3};
        vecs[6] = '{32'd16777219, 32'h4B800002, 9};
`else
        vecs[5] = '{32'h7FFFFFFF, 32'h4EFFFFFF, 3};
        vecs[6] = '{32'd16777219, 32'h4B800001, 9};
`endif
        vecs[0]  = '{32'd30,        32'h41F00000, 29};
        vecs[1]  = '{32'd10,        32'h41200000, 30};
        vecs[2]  = '{32'd0,         32'h00000000, 0};   // accept edge loads DONE
        vecs[3]  = '{32'hFFFFFFFF,  32'hBF800000, 33};
        vecs[4]  = '{32'h80000000,  32'hCF000000, 2};
        vecs[7]  = '{32'd16777217,  32'h4B800000, 9};   // tie, even stays
        vecs[8]  = '{32'd1,         32'h3F800000, 33};
        vecs[9]  = '{32'hFFFFFFF6,  32'hC1200000, 30};
        vecs[10] = '{32'd3,         32'h40400000, 32};
        vecs[11] = '{32'h00FFFFFF,  32'h4B7FFFFF, 10};
        vecs[12] = '{32'd0,         32'h00000000, 0};

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_int    = '0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_fp",    out_fp,             32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].in_int, fp, lat);
            check($sformatf("fp[%0d]", i),  fp,           vecs[i].fp);
            check($sformatf("lat[%0d]", i), 32'(lat),     32'(vecs[i].lat));
            check($sformatf("busy_done[%0d]", i), {31'd0, busy}, 32'd1);
            consume(vecs[i].fp);
        end

        // Hold in DONE with stray operands offered.
        run_op(32'd30, fp, lat);
        check("hold_first_fp", fp, 32'h41F00000);
        held = fp;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0];
            in_int   = 32'd7 + 32'(c);
            @(posedge clk);
            #1;
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out_fp",    out_fp,             held);
            check("hold_in_ready",  {31'd0, in_ready},  32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume(held);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (busy || out_valid) seen++;
        end
        check("no_queued_operand", 32'(seen), 32'd0);

        // Reset during normalisation of 1.
        @(negedge clk);
        in_int   = 32'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_in_ready",  {31'd0, in_ready},  32'd1);
        check("midreset_busy",      {31'd0, busy},      32'd0);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midreset_no_pulse", 32'(seen), 32'd0);
        run_op(32'd10, fp, lat);
        check("after_reset_fp",  fp,       32'h41200000);
        check("after_reset_lat", 32'(lat), 32'd30);
        consume(32'h41200000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_int_to_fp_seq
`default_nettype wire
